// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory/writeback pipeline stage.
package mem_wb_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Request/acknowledge data-memory bus between the MEM/WB stage and the data memory.
interface mem_wb_stage_if #(
    parameter int N = 32
) ();
    logic         req;
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rdata;
    logic         ack;

    modport master (output req, output we, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: runs loads/stores over the req/ack bus, retires results to the
// register-file write port, stalls upstream while an access is outstanding.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [N-1:0]    RD2_i,
    input  logic [N-1:0]    AluResult_i,
    input  logic            RF_WE_i,
    input  logic            MemWE_i,
    input  logic            WBSelect_i,
    input  logic [3:0]      A3_i,
    output logic            stall_o,
    output logic            RF_WE_o,
    output logic [3:0]      A3_o,
    output logic [N-1:0]    WD3_o,
    output logic            err_o,
    mem_wb_stage_if.master  mem
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

    mem_state_t    state;
    mem_state_t    next_state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    lat_a3;
    logic          lat_rf_we;
    logic          start_alu;
    logic          start_mem;
    logic          got_ack;
    logic          timed_out;

    // A store always wins over a load when both flags are set.
    always_comb begin
        start_alu = (state == IDLE) && valid_i && !MemWE_i && (WBSelect_i == WB_ALU);
        start_mem = (state == IDLE) && valid_i && (MemWE_i || (WBSelect_i == WB_MEM));
        got_ack   = (state == ACCESS) && mem.req && mem.ack;
        timed_out = (state == ACCESS) && !mem.ack && (wait_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_mem) next_state = ACCESS;
            ACCESS:  if (got_ack || timed_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall_o = (state == ACCESS);
    end

    // Bus drive, wait counter and writeback registers; RF_WE_o is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            wait_cnt  <= '0;
            lat_a3    <= '0;
            lat_rf_we <= 1'b0;
            RF_WE_o   <= 1'b0;
            A3_o      <= '0;
            WD3_o     <= '0;
            err_o     <= 1'b0;
        end else begin
            RF_WE_o <= 1'b0;
            if (start_alu) begin
                RF_WE_o <= RF_WE_i;
                A3_o    <= A3_i;
                WD3_o   <= AluResult_i;
            end
            if (start_mem) begin
                mem.req   <= 1'b1;
                mem.we    <= MemWE_i;
                mem.addr  <= AluResult_i;
                mem.wdata <= RD2_i;
                lat_a3    <= A3_i;
                lat_rf_we <= RF_WE_i && !MemWE_i;
                wait_cnt  <= '0;
            end
            if (got_ack) begin
                mem.req <= 1'b0;
                if (!mem.we) begin
                    RF_WE_o <= lat_rf_we;
                    A3_o    <= lat_a3;
                    WD3_o   <= mem.rdata;
                end
            end else if (timed_out) begin
                mem.req <= 1'b0;
                err_o   <= 1'b1;
            end else if ((state == ACCESS) && (wait_cnt != CNT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: ALU vector table plus load/store/timeout/reset sequences.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [31:0] RD2_i;
    logic [31:0] AluResult_i;
    logic        RF_WE_i;
    logic        MemWE_i;
    logic        WBSelect_i;
    logic [3:0]  A3_i;
    logic        stall_o;
    logic        RF_WE_o;
    logic [3:0]  A3_o;
    logic [31:0] WD3_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    mem_wb_stage_if #(.N(32)) mem_bus ();

    mem_wb_stage #(.N(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .RD2_i       (RD2_i),
        .AluResult_i (AluResult_i),
        .RF_WE_i     (RF_WE_i),
        .MemWE_i     (MemWE_i),
        .WBSelect_i  (WBSelect_i),
        .A3_i        (A3_i),
        .stall_o     (stall_o),
        .RF_WE_o     (RF_WE_o),
        .A3_o        (A3_o),
        .WD3_o       (WD3_o),
        .err_o       (err_o),
        .mem         (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, need $finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        valid;
        logic        rfWe;
        logic [3:0]  a3;
        logic [31:0] alu;
        logic        expWe;
        logic [3:0]  expA3;
        logic [31:0] expWd;
    } vec_t;

    vec_t vecs[6];

    task automatic applyStimulus(input logic valid, input logic memWe, input logic wbSel,
                                 input logic rfWe, input logic [3:0] a3,
                                 input logic [31:0] alu, input logic [31:0] rd2);
        valid_i     = valid;
        MemWE_i     = memWe;
        WBSelect_i  = wbSel;
        RF_WE_i     = rfWe;
        A3_i        = a3;
        AluResult_i = alu;
        RD2_i       = rd2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issues one memory op, raises ack during ACCESS cycle ackCycle (0 = never) and
    // observes 12 cycles: stall count, strobe count and the cycle the strobe appeared.
    task automatic doMemOp(input logic memWe, input logic wbSel, input logic [3:0] a3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ackCycle, input logic [31:0] rdata,
                           output int stallCnt, output int strobeCnt, output int strobeAt);
        applyStimulus(1'b1, memWe, wbSel, 1'b1, a3, addr, wdata);
        stallCnt  = 0;
        strobeCnt = 0;
        strobeAt  = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
            mem_bus.ack = 1'b0;
            if (c == 1) begin
                checkOutput("bus_req", {31'd0, mem_bus.req}, 32'd1);
                checkOutput("bus_we", {31'd0, mem_bus.we}, {31'd0, memWe});
                checkOutput("bus_addr", mem_bus.addr, addr);
                if (memWe) checkOutput("bus_wdata", mem_bus.wdata, wdata);
            end
            if (stall_o) stallCnt++;
            if (RF_WE_o) begin
                strobeCnt++;
                strobeAt = c;
            end
            if (c == ackCycle) begin
                mem_bus.ack   = 1'b1;
                mem_bus.rdata = rdata;
            end
        end
        mem_bus.ack = 1'b0;
    endtask

    int stallCnt, strobeCnt, strobeAt;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'd5, 32'h4,        1'b1, 4'd5, 32'h4};
        vecs[1] = '{1'b0, 1'b0, 4'd0, 32'h0,        1'b0, 4'd5, 32'h4};
        vecs[2] = '{1'b1, 1'b1, 4'd7, 32'hDEADBEEF, 1'b1, 4'd7, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 4'd9, 32'h1234,     1'b1, 4'd9, 32'h1234};
        vecs[4] = '{1'b1, 1'b0, 4'd3, 32'h55,       1'b0, 4'd3, 32'h55};
        vecs[5] = '{1'b0, 1'b1, 4'd8, 32'h99,       1'b0, 4'd3, 32'h55};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rst_req", {31'd0, mem_bus.req}, 32'd0);
        checkOutput("rst_rfwe", {31'd0, RF_WE_o}, 32'd0);
        checkOutput("rst_wd3", WD3_o, 32'd0);
        checkOutput("rst_err", {31'd0, err_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, 1'b0, 1'b0, vecs[i].rfWe, vecs[i].a3, vecs[i].alu, 32'hFFFF);
            @(negedge clk);
            checkOutput($sformatf("alu%0d_we", i), {31'd0, RF_WE_o}, {31'd0, vecs[i].expWe});
            checkOutput($sformatf("alu%0d_a3", i), {28'd0, A3_o}, {28'd0, vecs[i].expA3});
            checkOutput($sformatf("alu%0d_wd3", i), WD3_o, vecs[i].expWd);
            checkOutput($sformatf("alu%0d_stall", i), {31'd0, stall_o}, 32'd0);
            checkOutput($sformatf("alu%0d_req", i), {31'd0, mem_bus.req}, 32'd0);
        end

        $display("[TB] load with ack in third access cycle");
        doMemOp(1'b0, 1'b1, 4'd2, 32'h10, 32'h0, 3, 32'hCAFE, stallCnt, strobeCnt, strobeAt);
        checkOutput("ld_stall_cycles", stallCnt, 32'd3);
        checkOutput("ld_strobes", strobeCnt, 32'd1);
        checkOutput("ld_strobe_at", strobeAt, 32'd4);
        checkOutput("ld_a3", {28'd0, A3_o}, 32'd2);
        checkOutput("ld_wd3", WD3_o, 32'hCAFE);
        checkOutput("ld_req_done", {31'd0, mem_bus.req}, 32'd0);

        $display("[TB] store with ack in first access cycle");
        doMemOp(1'b1, 1'b0, 4'd6, 32'h20, 32'h3, 1, 32'hBAD, stallCnt, strobeCnt, strobeAt);
        checkOutput("st_stall_cycles", stallCnt, 32'd1);
        checkOutput("st_strobes", strobeCnt, 32'd0);
        checkOutput("st_wd3_hold", WD3_o, 32'hCAFE);

        $display("[TB] store with writeback select also set");
        doMemOp(1'b1, 1'b1, 4'd6, 32'h24, 32'h7, 2, 32'hBAD, stallCnt, strobeCnt, strobeAt);
        checkOutput("stwb_stall_cycles", stallCnt, 32'd2);
        checkOutput("stwb_strobes", strobeCnt, 32'd0);
        checkOutput("stwb_a3_hold", {28'd0, A3_o}, 32'd2);

        $display("[TB] ack on the timeout cycle");
        doMemOp(1'b0, 1'b1, 4'd11, 32'h30, 32'h0, 4, 32'h1357, stallCnt, strobeCnt, strobeAt);
        checkOutput("edge_stall_cycles", stallCnt, 32'd4);
        checkOutput("edge_strobes", strobeCnt, 32'd1);
        checkOutput("edge_wd3", WD3_o, 32'h1357);
        checkOutput("edge_err", {31'd0, err_o}, 32'd0);

        $display("[TB] load timeout");
        doMemOp(1'b0, 1'b1, 4'd12, 32'h40, 32'h0, 0, 32'h0, stallCnt, strobeCnt, strobeAt);
        checkOutput("to_stall_cycles", stallCnt, 32'd4);
        checkOutput("to_strobes", strobeCnt, 32'd0);
        checkOutput("to_err", {31'd0, err_o}, 32'd1);
        checkOutput("to_req", {31'd0, mem_bus.req}, 32'd0);
        checkOutput("to_wd3_hold", WD3_o, 32'h1357);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 32'h77, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("post_to_we", {31'd0, RF_WE_o}, 32'd1);
        checkOutput("post_to_wd3", WD3_o, 32'h77);
        checkOutput("post_to_err_sticky", {31'd0, err_o}, 32'd1);

        mem_bus.ack = 1'b1;
        @(negedge clk);
        mem_bus.ack = 1'b0;
        checkOutput("stray_ack_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("stray_ack_we", {31'd0, RF_WE_o}, 32'd0);

        $display("[TB] reset during an access");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h50, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        checkOutput("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_req", {31'd0, mem_bus.req}, 32'd0);
        checkOutput("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("mid_rst_we", {31'd0, RF_WE_o}, 32'd0);
        checkOutput("mid_rst_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doMemOp(1'b0, 1'b1, 4'd14, 32'h60, 32'h0, 1, 32'hA5A5, stallCnt, strobeCnt, strobeAt);
        checkOutput("post_rst_strobes", strobeCnt, 32'd1);
        checkOutput("post_rst_strobe_at", strobeAt, 32'd2);
        checkOutput("post_rst_a3", {28'd0, A3_o}, 32'd14);
        checkOutput("post_rst_wd3", WD3_o, 32'hA5A5);
        checkOutput("post_rst_err", {31'd0, err_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
